uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Parametrised UART receive controller; replaces the fixed 8N1 receiver control unit.
//  Owns the bit timer, bit counter, LSB-first shift register, parity/stop checking and output buffer handshake.
//  Sits between the start-bit edge detector (sync'd serial_in) and the host-side read interface.
//  Adds over the old unit: configurable width/rate/parity/stop, false-start rejection, overrun detection.
// PARAMETERS
//  DATA_BITS     8   data bits per frame, legal 5..9
//  CLKS_PER_BIT  10  clk cycles per bit period, even, >=4
//  PARITY_EN     0   1: one parity bit follows data
//  PARITY_ODD    0   1: odd parity, 0: even (ignored if PARITY_EN=0)
//  STOP_BITS     1   stop bits checked, 1 or 2
// PORTS
//  clk                 in   1          system clock
//  n_rst               in   1          reset, asynchronous, active-low
//  serial_in           in   1          synchronised serial line, idle high
//  start_bit_detected  in   1          1-cycle pulse from edge detector
//  data_read           in   1          host consumed rx_data (1-cycle pulse)
//  rx_data             out  DATA_BITS  received byte buffer
//  data_ready          out  1          rx_data valid, unread
//  rx_busy             out  1          frame in progress (state != IDLE)
//  shift_strobe        out  1          1-cycle pulse at each data-bit sample
//  load_buffer         out  1          1-cycle pulse when rx_data is updated
//  parity_error        out  1          sticky, last frame parity mismatch
//  framing_error       out  1          sticky, last frame had a 0 stop bit
//  overrun_error       out  1          sticky, buffer overwritten while unread
// BEHAVIOUR
//  Reset: all outputs 0, rx_data=0, state IDLE, counters 0. Reset mid-frame aborts frame, no load.
//  HALF = CLKS_PER_BIT/2; cnt = bit timer, 0..CLKS_PER_BIT-1; bcnt = bit counter.
//  States: IDLE, START, DATA, PARITY, STOP, CHECK, LOAD (Moore, registered state).
//  IDLE: start_bit_detected=1 -> START, cnt=0; parity_error/framing_error cleared on this edge.
//   start_bit_detected is ignored in every other state.
//  START: cnt++; at cnt==HALF-1 sample serial_in: 1 -> IDLE (false start, no flags); 0 -> DATA, cnt=0, bcnt=0.
//  DATA: at cnt==CLKS_PER_BIT-1: shift_strobe=1 (same cycle); shift serial_in into MSB, shift right (LSB-first).
//   Update running XOR and bcnt; reset cnt.
//   After DATA_BITS-th sample -> PARITY if PARITY_EN else STOP.
//  PARITY: sample at cnt==CLKS_PER_BIT-1; perr = (xor ^ bit) != PARITY_ODD -> STOP.
//  STOP: sample at cnt==CLKS_PER_BIT-1, STOP_BITS times; any 0 sets ferr; after last -> CHECK.
//  CHECK (1 cycle): parity_error<=perr, framing_error<=ferr; no error -> LOAD, else IDLE (rx_data unchanged).
//  LOAD (1 cycle): load_buffer=1, rx_data<=shift reg, data_ready<=1 -> IDLE.
//  Overrun: load while data_ready=1 and data_read=0 -> overrun_error<=1, new data overwrites.
//   Load and data_read in the same cycle -> no overrun, data_ready stays 1.
//  data_ready clears on data_read when no load in that cycle.
//  overrun_error clears only on data_read.
//  Latency: LOAD at T0 + HALF + (DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT + 1, where T0 = first START cycle.
//  Timer wrap: cnt returns to 0 after each sample; never exceeds CLKS_PER_BIT-1.
// STRUCTURE
//  Package uart_rx_pkg holds:
//   typedef enum logic [2:0] rx_state_t {IDLE,START,DATA,PARITY,STOP,CHECK,LOAD}
//   localparams for legal parameter ranges
//  Sub-module uart_bit_timer: counter with clear/enable, rollover value input, 1-cycle sample pulse.
//  Parameter legality checked by elaboration-time assertion.
// TESTING
//  8N1, CLKS=10, frame 0xA5 -> shift_strobe at T0+14+10k (k=0..7), load_buffer at T0+96, rx_data=0xA5, data_ready=1.
//  serial_in back high at T0+3 (glitch) -> return to IDLE at T0+5, no strobes, no flags.
//  8E1, data 0x07 with parity bit 0 -> parity_error=1, no load, data_ready unchanged; next good frame clears it.
//  8N2, second stop bit 0 -> framing_error=1, no load_buffer pulse; start of next frame clears framing_error.
//  Two frames 0x11, 0x22, no data_read -> overrun_error=1, rx_data=0x22; data_read -> data_ready=0, overrun_error=0.
//  n_rst low at T0+40 -> all outputs 0 immediately; start pulse after release receives next frame correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types, legal parameter ranges and the parity helper for the UART receive controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHECK  = 3'd5,
    LOAD   = 3'd6
  } rx_state_t;

  localparam int DATA_BITS_MIN    = 5;
  localparam int DATA_BITS_MAX    = 9;
  localparam int CLKS_PER_BIT_MIN = 4;
  localparam int STOP_BITS_MIN    = 1;
  localparam int STOP_BITS_MAX    = 2;

  // Returns 1 when the received parity bit disagrees with the selected parity sense.
  function automatic logic parity_mismatch(input logic data_xor, input logic parity_bit,
                                           input logic odd);
    return ((data_xor ^ parity_bit) != odd);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts while enabled, wraps to zero on the sample cycle and flags it.
module uart_bit_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] rollover,
  output logic [CNT_W-1:0] cnt,
  output logic             sample
);

  logic [CNT_W-1:0] cnt_r;

  // Count up while enabled; return to zero on the sample cycle or on clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == rollover) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign cnt    = cnt_r;
  assign sample = en & (cnt_r == rollover);

endmodule

// File: rtl/uart_rx_ctrl.sv
// Parametrised UART receive controller: start validation, LSB-first data capture,
// optional parity, 1 or 2 stop bits, output buffer with ready/overrun handshake.
module uart_rx_ctrl import uart_rx_pkg::*; #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 start_bit_detected,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 rx_busy,
  output logic                 shift_strobe,
  output logic                 load_buffer,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error
);

  localparam int HALF   = CLKS_PER_BIT / 2;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BCNT_W = 4;

  generate
    if ((DATA_BITS < DATA_BITS_MIN) || (DATA_BITS > DATA_BITS_MAX) ||
        (CLKS_PER_BIT < CLKS_PER_BIT_MIN) || ((CLKS_PER_BIT % 2) != 0) ||
        (STOP_BITS < STOP_BITS_MIN) || (STOP_BITS > STOP_BITS_MAX) ||
        (PARITY_EN < 0) || (PARITY_EN > 1) || (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_param_bad
      $error("uart_rx_ctrl: illegal parameter combination");
    end
  endgenerate

  rx_state_t            state_r;
  rx_state_t            next_state_s;
  logic                 tmr_clr_s;
  logic                 tmr_en_s;
  logic [CNT_W-1:0]     rollover_s;
  logic [CNT_W-1:0]     cnt_s;
  logic                 sample_s;
  logic [BCNT_W-1:0]    bcnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 xor_r;
  logic                 perr_r;
  logic                 ferr_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 data_ready_r;
  logic                 rx_busy_r;
  logic                 shift_strobe_r;
  logic                 load_buffer_r;
  logic                 parity_error_r;
  logic                 framing_error_r;
  logic                 overrun_r;

  uart_bit_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (tmr_clr_s),
    .en       (tmr_en_s),
    .rollover (rollover_s),
    .cnt      (cnt_s),
    .sample   (sample_s)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and timer control; the START phase times only half a bit to land mid-bit.
  always_comb begin
    next_state_s = state_r;
    tmr_clr_s    = 1'b0;
    tmr_en_s     = 1'b0;
    rollover_s   = CNT_W'(CLKS_PER_BIT - 1);
    case (state_r)
      IDLE: begin
        tmr_clr_s = 1'b1;
        if (start_bit_detected) begin
          next_state_s = START;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        tmr_en_s   = 1'b1;
        rollover_s = CNT_W'(HALF - 1);
        if (sample_s) begin
          if (serial_in) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = DATA;
          end
        end else begin
          next_state_s = START;
        end
      end
      DATA: begin
        tmr_en_s = 1'b1;
        if (sample_s && (bcnt_r == BCNT_W'(DATA_BITS - 1))) begin
          next_state_s = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          next_state_s = DATA;
        end
      end
      PARITY: begin
        tmr_en_s = 1'b1;
        if (sample_s) begin
          next_state_s = STOP;
        end else begin
          next_state_s = PARITY;
        end
      end
      STOP: begin
        tmr_en_s = 1'b1;
        if (sample_s && (bcnt_r == BCNT_W'(STOP_BITS - 1))) begin
          next_state_s = CHECK;
        end else begin
          next_state_s = STOP;
        end
      end
      CHECK: begin
        tmr_clr_s = 1'b1;
        if (perr_r || ferr_r) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = LOAD;
        end
      end
      LOAD: begin
        tmr_clr_s    = 1'b1;
        next_state_s = IDLE;
      end
      default: begin
        tmr_clr_s    = 1'b1;
        next_state_s = IDLE;
      end
    endcase
  end

  // Frame datapath: bit counter, shift register, running parity and sticky error flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bcnt_r          <= '0;
      shift_r         <= '0;
      xor_r           <= 1'b0;
      perr_r          <= 1'b0;
      ferr_r          <= 1'b0;
      rx_data_r       <= '0;
      parity_error_r  <= 1'b0;
      framing_error_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_bit_detected) begin
            parity_error_r  <= 1'b0;
            framing_error_r <= 1'b0;
          end
        end
        START: begin
          bcnt_r <= '0;
          xor_r  <= 1'b0;
          perr_r <= 1'b0;
          ferr_r <= 1'b0;
        end
        DATA: begin
          if (sample_s) begin
            shift_r <= {serial_in, shift_r[DATA_BITS-1:1]};
            xor_r   <= xor_r ^ serial_in;
            if (bcnt_r == BCNT_W'(DATA_BITS - 1)) begin
              bcnt_r <= '0;
            end else begin
              bcnt_r <= bcnt_r + BCNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (sample_s) begin
            perr_r <= parity_mismatch(xor_r, serial_in, (PARITY_ODD != 0));
          end
        end
        STOP: begin
          if (sample_s) begin
            bcnt_r <= bcnt_r + BCNT_W'(1);
            if (!serial_in) begin
              ferr_r <= 1'b1;
            end
          end
        end
        CHECK: begin
          parity_error_r  <= perr_r;
          framing_error_r <= ferr_r;
        end
        LOAD: begin
          rx_data_r <= shift_r;
        end
        default: begin
          bcnt_r <= '0;
        end
      endcase
    end
  end

  // Host handshake: a load sets ready (flagging overrun if unread), a read clears ready and overrun.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_ready_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (state_r == LOAD) begin
      data_ready_r <= 1'b1;
      if (data_read) begin
        overrun_r <= 1'b0;
      end else if (data_ready_r) begin
        overrun_r <= 1'b1;
      end
    end else if (data_read) begin
      data_ready_r <= 1'b0;
      overrun_r    <= 1'b0;
    end
  end

  // Registered status pulses, decoded one cycle early so they align with the state they mark.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_busy_r      <= 1'b0;
      load_buffer_r  <= 1'b0;
      shift_strobe_r <= 1'b0;
    end else begin
      rx_busy_r      <= (next_state_s != IDLE);
      load_buffer_r  <= (next_state_s == LOAD);
      shift_strobe_r <= (state_r == DATA) && (cnt_s == CNT_W'(CLKS_PER_BIT - 2));
    end
  end

  assign rx_data       = rx_data_r;
  assign data_ready    = data_ready_r;
  assign rx_busy       = rx_busy_r;
  assign shift_strobe  = shift_strobe_r;
  assign load_buffer   = load_buffer_r;
  assign parity_error  = parity_error_r;
  assign framing_error = framing_error_r;
  assign overrun_error = overrun_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: instance 0 is 8N1, instance 1 is 8E2; both at 10 clocks per bit.
module tb_uart_rx_ctrl;

  localparam int CLKS = 10;

  logic        clk;
  logic        n_rst;
  logic [1:0]  ser;
  logic [1:0]  sbd;
  logic [1:0]  rd;
  logic [15:0] rxd;
  logic [1:0]  dr, busy, ss, lb, pe, fe, oe;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t0    = 0;

  logic [7:0] m_data  [2];
  logic       m_ready [2];
  logic       m_ovr   [2];
  logic       m_perr  [2];
  logic       m_ferr  [2];
  int         m_loads [2];
  int         lb_cnt  [2];
  int         sq_a[$];
  int         lq_a[$];

  uart_rx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(CLKS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .clk(clk), .n_rst(n_rst), .serial_in(ser[0]), .start_bit_detected(sbd[0]), .data_read(rd[0]),
    .rx_data(rxd[7:0]), .data_ready(dr[0]), .rx_busy(busy[0]), .shift_strobe(ss[0]),
    .load_buffer(lb[0]), .parity_error(pe[0]), .framing_error(fe[0]), .overrun_error(oe[0]));

  uart_rx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(CLKS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_b (
    .clk(clk), .n_rst(n_rst), .serial_in(ser[1]), .start_bit_detected(sbd[1]), .data_read(rd[1]),
    .rx_data(rxd[15:8]), .data_ready(dr[1]), .rx_busy(busy[1]), .shift_strobe(ss[1]),
    .load_buffer(lb[1]), .parity_error(pe[1]), .framing_error(fe[1]), .overrun_error(oe[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record strobe/load cycles of the 8N1 instance and count loads on both.
  always @(negedge clk) begin
    if (ss[0]) sq_a.push_back(cyc);
    if (lb[0]) begin lq_a.push_back(cyc); lb_cnt[0] = lb_cnt[0] + 1; end
    if (lb[1]) lb_cnt[1] = lb_cnt[1] + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rx_of(input int sel);
    return (sel == 0) ? rxd[7:0] : rxd[15:8];
  endfunction

  task automatic check_all(input int sel, input string tag);
    chk({tag, ".rx_data"},  16'(rx_of(sel)), 16'(m_data[sel]));
    chk({tag, ".ready"},    16'(dr[sel]),    16'(m_ready[sel]));
    chk({tag, ".overrun"},  16'(oe[sel]),    16'(m_ovr[sel]));
    chk({tag, ".parity"},   16'(pe[sel]),    16'(m_perr[sel]));
    chk({tag, ".framing"},  16'(fe[sel]),    16'(m_ferr[sel]));
    chk({tag, ".busy"},     16'(busy[sel]),  16'd0);
    chk({tag, ".loads"},    16'(lb_cnt[sel]), 16'(m_loads[sel]));
  endtask

  task automatic check_reset_outputs(input int sel, input string tag);
    chk({tag, ".rx_data"}, 16'(rx_of(sel)), 16'd0);
    chk({tag, ".ready"},   16'(dr[sel]),    16'd0);
    chk({tag, ".busy"},    16'(busy[sel]),  16'd0);
    chk({tag, ".strobe"},  16'(ss[sel]),    16'd0);
    chk({tag, ".load"},    16'(lb[sel]),    16'd0);
    chk({tag, ".flags"},   16'({pe[sel], fe[sel], oe[sel]}), 16'd0);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_data[s] = 8'h00; m_ready[s] = 1'b0; m_ovr[s] = 1'b0; m_perr[s] = 1'b0; m_ferr[s] = 1'b0;
    end
  endtask

  // Model of one complete frame: error frames only update flags; good frames update the buffer.
  task automatic expect_frame(input int sel, input logic [7:0] d, input logic perr, input logic ferr,
                              input bit rdl);
    m_perr[sel] = perr;
    m_ferr[sel] = ferr;
    if (!perr && !ferr) begin
      m_loads[sel]++;
      m_data[sel] = d;
      if (rdl) m_ovr[sel] = 1'b0;
      else if (m_ready[sel]) m_ovr[sel] = 1'b1;
      m_ready[sel] = 1'b1;
    end else if (rdl) begin
      m_ready[sel] = 1'b0;
      m_ovr[sel]   = 1'b0;
    end
  endtask

  // Drive one frame; bits are LSB-first after the start bit, each held for one bit period.
  task automatic send(input int sel, input logic [15:0] bits, input int nb, input bit rdl,
                      input int abort_at);
    int lat;
    lat = 6 + nb * CLKS;
    @(negedge clk); ser[sel] = 1'b0; sbd[sel] = 1'b1;
    @(negedge clk); sbd[sel] = 1'b0; t0 = cyc;
    if (sel == 0) begin sq_a.delete(); lq_a.delete(); end
    for (int c = 0; c < CLKS * (nb + 1); c++) begin
      if (c == 0) chk("flags_clear_on_start", 16'({pe[sel], fe[sel]}), 16'd0);
      if (c == abort_at) begin
        n_rst = 1'b0;
        #1;
        check_reset_outputs(sel, "mid_frame_reset");
        model_reset();
        @(negedge clk);
        n_rst = 1'b1; ser[sel] = 1'b1; rd[sel] = 1'b0;
        return;
      end
      ser[sel] = (c < CLKS) ? 1'b0 : bits[(c / CLKS) - 1];
      rd[sel]  = rdl && (c == lat);
      @(negedge clk);
    end
    ser[sel] = 1'b1;
    rd[sel]  = 1'b0;
  endtask

  task automatic pulse_read(input int sel);
    @(negedge clk); rd[sel] = 1'b1;
    @(negedge clk); rd[sel] = 1'b0;
    m_ready[sel] = 1'b0;
    m_ovr[sel]   = 1'b0;
  endtask

  function automatic logic [15:0] frame_a(input logic [7:0] d, input logic st);
    return {7'd0, st, d};
  endfunction

  function automatic logic [15:0] frame_b(input logic [7:0] d, input logic p, input logic s1,
                                          input logic s2);
    return {5'd0, s2, s1, p, d};
  endfunction

  initial begin
    logic [7:0] d;
    logic       p, s1, s2, perr, ferr;
    bit         rdl;
    int         sel;

    n_rst = 1'b0; ser = 2'b11; sbd = 2'b00; rd = 2'b00;
    lb_cnt[0] = 0; lb_cnt[1] = 0; m_loads[0] = 0; m_loads[1] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs(0, "reset_a");
    check_reset_outputs(1, "reset_b");
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5: strobe and load timing
    send(0, frame_a(8'hA5, 1'b1), 9, 1'b0, -1);
    expect_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5.strobe_count", 16'(sq_a.size()), 16'd8);
    for (int k = 0; k < 8; k++)
      if (k < sq_a.size()) chk("a5.strobe_cycle", 16'(sq_a[k] - t0), 16'(14 + 10 * k));
    chk("a5.load_count", 16'(lq_a.size()), 16'd1);
    if (lq_a.size() > 0) chk("a5.load_cycle", 16'(lq_a[0] - t0), 16'd96);
    check_all(0, "a5");

    // false start: line back high at T0+3
    @(negedge clk); ser[0] = 1'b0; sbd[0] = 1'b1;
    @(negedge clk); sbd[0] = 1'b0; t0 = cyc; sq_a.delete();
    for (int c = 0; c < 12; c++) begin
      ser[0] = (c >= 3) ? 1'b1 : 1'b0;
      if (c == 4) chk("glitch.busy_t4", 16'(busy[0]), 16'd1);
      if (c == 5) chk("glitch.busy_t5", 16'(busy[0]), 16'd0);
      @(negedge clk);
    end
    chk("glitch.strobes", 16'(sq_a.size()), 16'd0);
    check_all(0, "glitch");

    // 8E2: good frame, then parity error, then framing error on second stop bit
    send(1, frame_b(8'h3C, 1'b0, 1'b1, 1'b1), 11, 1'b0, -1);
    expect_frame(1, 8'h3C, 1'b0, 1'b0, 1'b0);
    check_all(1, "b_good");
    send(1, frame_b(8'h07, 1'b0, 1'b1, 1'b1), 11, 1'b0, -1);
    expect_frame(1, 8'h07, 1'b1, 1'b0, 1'b0);
    check_all(1, "b_perr");
    send(1, frame_b(8'h07, 1'b1, 1'b1, 1'b1), 11, 1'b0, -1);
    expect_frame(1, 8'h07, 1'b0, 1'b0, 1'b0);
    check_all(1, "b_perr_cleared");
    pulse_read(1);
    send(1, frame_b(8'h81, 1'b0, 1'b1, 1'b0), 11, 1'b0, -1);
    expect_frame(1, 8'h81, 1'b0, 1'b1, 1'b0);
    check_all(1, "b_ferr");

    // overrun, then read clears, then load coinciding with read
    pulse_read(0);
    send(0, frame_a(8'h11, 1'b1), 9, 1'b0, -1);
    expect_frame(0, 8'h11, 1'b0, 1'b0, 1'b0);
    send(0, frame_a(8'h22, 1'b1), 9, 1'b0, -1);
    expect_frame(0, 8'h22, 1'b0, 1'b0, 1'b0);
    check_all(0, "overrun");
    pulse_read(0);
    check_all(0, "overrun_read");
    send(0, frame_a(8'h33, 1'b1), 9, 1'b0, -1);
    expect_frame(0, 8'h33, 1'b0, 1'b0, 1'b0);
    send(0, frame_a(8'h44, 1'b1), 9, 1'b1, -1);
    expect_frame(0, 8'h44, 1'b0, 1'b0, 1'b1);
    check_all(0, "load_with_read");

    // reset at T0+40 aborts the frame; the next frame is received normally
    send(0, frame_a(8'h5A, 1'b1), 9, 1'b0, 40);
    repeat (2) @(negedge clk);
    check_all(0, "after_reset_a");
    check_all(1, "after_reset_b");
    send(0, frame_a(8'h96, 1'b1), 9, 1'b0, -1);
    expect_frame(0, 8'h96, 1'b0, 1'b0, 1'b0);
    check_all(0, "after_reset_frame");

    // randomized frames with occasional parity/stop errors and reads
    for (int i = 0; i < 12; i++) begin
      sel = int'($urandom_range(0, 1));
      d   = 8'($urandom);
      rdl = ($urandom_range(0, 3) == 0);
      if (sel == 0) begin
        s1   = ($urandom_range(0, 4) != 0);
        ferr = !s1;
        send(0, frame_a(d, s1), 9, rdl, -1);
        expect_frame(0, d, 1'b0, ferr, rdl);
      end else begin
        p    = ^d ^ ($urandom_range(0, 3) == 0);
        s1   = ($urandom_range(0, 4) != 0);
        s2   = ($urandom_range(0, 4) != 0);
        perr = (($countones({p, d}) % 2) != 0);
        ferr = !(s1 && s2);
        send(1, frame_b(d, p, s1, s2), 11, rdl, -1);
        expect_frame(1, d, perr, ferr, rdl);
      end
      check_all(sel, "random");
      if ($urandom_range(0, 2) == 0) begin
        pulse_read(sel);
        check_all(sel, "random_read");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
